// File: rtl/pipeline_vector_pkg.sv
// Shared helpers for select-field staircases: digit offsets and register counts.
// The mux/demux tree wrappers use the same helpers.
package pipeline_vector_pkg;

    function automatic int digit_lo(input int k, input int width);
        return k * width;
    endfunction

    // Number of digit registers in a staircase over n digits: 0+1+...+(n-1).
    function automatic int tri_regs(input int n);
        return n * (n - 1) / 2;
    endfunction

    function automatic int reg_count(input int width, input int size, input int pre);
        return width * (size * pre + tri_regs(size));
    endfunction

endpackage

// File: rtl/pipeline_vector_synchronizer.sv
// Plain DEPTH-stage register chain with async active-high clear.
// DEPTH=0 degenerates to a wire.
module pipeline_vector_synchronizer #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign o_q      = i_d;
    end else begin : g_regs
        logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pipe <= '0;
            end else begin
                r_pipe[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign o_q = r_pipe[DEPTH-1];
    end

endmodule

// File: rtl/pipeline_vector.sv
// Skewed select-field delay line: digit k of the select word leaves PRE_DELAY+k
// cycles after sel_in, so each mux/demux tree level sees its digit with its data.
module pipeline_vector
    import pipeline_vector_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int SIZE      = 2,
    parameter int PRE_DELAY = 0,
    parameter int REVERSE   = 1,
    parameter int PRINT     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIZE*WIDTH-1:0] sel_in,
    output logic [SIZE*WIDTH-1:0] sel_stair,
    output logic [SIZE*WIDTH-1:0] sel_out
);

    if (WIDTH < 1 || SIZE < 1 || PRE_DELAY < 0) begin : g_bad_params
        $fatal(1, "pipeline_vector: WIDTH and SIZE must be >=1, PRE_DELAY >=0");
    end

    if (PRINT != 0) begin : g_print
        $info("pipeline_vector: %0d registers", reg_count(WIDTH, SIZE, PRE_DELAY));
    end

    logic [SIZE*WIDTH-1:0] w_pre;

    pipeline_vector_synchronizer #(
        .WIDTH (SIZE*WIDTH),
        .DEPTH (PRE_DELAY)
    ) u_pre (
        .clk (clk),
        .rst (rst),
        .i_d (sel_in),
        .o_q (w_pre)
    );

    // Each digit gets exactly k registers, so nothing is held longer than needed.
    for (genvar k = 0; k < SIZE; k++) begin : g_stair
        localparam int LO  = digit_lo(k, WIDTH);
        localparam int RLO = digit_lo(SIZE - 1 - k, WIDTH);

        pipeline_vector_synchronizer #(
            .WIDTH (WIDTH),
            .DEPTH (k)
        ) u_digit (
            .clk (clk),
            .rst (rst),
            .i_d (w_pre[LO +: WIDTH]),
            .o_q (sel_stair[LO +: WIDTH])
        );

        if (REVERSE != 0) begin : g_rev
            assign sel_out[LO +: WIDTH] = sel_stair[RLO +: WIDTH];
        end else begin : g_fwd
            assign sel_out[LO +: WIDTH] = sel_stair[LO +: WIDTH];
        end
    end

endmodule

// File: tb/tb_pipeline_vector.sv
// Bench for pipeline_vector: several configurations side by side, each checked
// against a history-queue model of "digit k = digit k of sel_in PRE_DELAY+k cycles ago".
module tb_pipeline_vector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Model state per stream: id0 -> A/B, id1 -> C, id2 -> D, id3 -> R, id4 -> E
    logic [31:0] cur  [5];
    logic [31:0] hist [5][8];
    int CW [5] = '{2, 1, 4, 3, 3};
    int CS [5] = '{3, 2, 3, 4, 1};
    int CP [5] = '{0, 2, 0, 2, 0};

    int n_vec = 0;
    int n_mis = 0;
    int cnt   = 0;

    logic [5:0] exp_a [5] = '{6'b000001, 6'b001000, 6'b110000, 6'b000000, 6'b000000};
    logic [5:0] exp_b [5] = '{6'b010000, 6'b001000, 6'b000011, 6'b000000, 6'b000000};
    logic [1:0] exp_c [5] = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b11};

    logic [5:0]  sel_a, a_stair, a_out, b_stair, b_out;
    logic [1:0]  sel_c, c_stair, c_out;
    logic [11:0] sel_d, d_stair, d_out;
    logic [11:0] sel_r, r_stair, r_out;
    logic [2:0]  sel_e, e_stair, e_out;

    assign sel_a = cur[0][5:0];
    assign sel_c = cur[1][1:0];
    assign sel_d = cur[2][11:0];
    assign sel_r = cur[3][11:0];
    assign sel_e = cur[4][2:0];

    pipeline_vector #(.WIDTH(2), .SIZE(3), .PRE_DELAY(0), .REVERSE(0), .PRINT(0)) u_a (
        .clk(clk), .rst(rst), .sel_in(sel_a), .sel_stair(a_stair), .sel_out(a_out));
    pipeline_vector #(.WIDTH(2), .SIZE(3), .PRE_DELAY(0), .REVERSE(1), .PRINT(0)) u_b (
        .clk(clk), .rst(rst), .sel_in(sel_a), .sel_stair(b_stair), .sel_out(b_out));
    pipeline_vector #(.WIDTH(1), .SIZE(2), .PRE_DELAY(2), .REVERSE(1), .PRINT(0)) u_c (
        .clk(clk), .rst(rst), .sel_in(sel_c), .sel_stair(c_stair), .sel_out(c_out));
    pipeline_vector #(.WIDTH(4), .SIZE(3), .PRE_DELAY(0), .REVERSE(0), .PRINT(0)) u_d (
        .clk(clk), .rst(rst), .sel_in(sel_d), .sel_stair(d_stair), .sel_out(d_out));
    pipeline_vector #(.WIDTH(3), .SIZE(4), .PRE_DELAY(2), .REVERSE(1), .PRINT(0)) u_r (
        .clk(clk), .rst(rst), .sel_in(sel_r), .sel_stair(r_stair), .sel_out(r_out));
    pipeline_vector #(.WIDTH(3), .SIZE(1), .PRE_DELAY(0), .REVERSE(1), .PRINT(0)) u_e (
        .clk(clk), .rst(rst), .sel_in(sel_e), .sel_stair(e_stair), .sel_out(e_out));

    function automatic logic [31:0] m_stair(input int id);
        logic [31:0] r;
        logic [31:0] src;
        int d;
        r = '0;
        for (int k = 0; k < CS[id]; k++) begin
            d   = CP[id] + k;
            src = (d == 0) ? cur[id] : hist[id][d-1];
            for (int b = 0; b < CW[id]; b++) r[k*CW[id]+b] = src[k*CW[id]+b];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_rev(input int id, input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < CS[id]; k++)
            for (int b = 0; b < CW[id]; b++)
                r[k*CW[id]+b] = x[(CS[id]-1-k)*CW[id]+b];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("A stair", 32'(a_stair), m_stair(0));
        chk("A out",   32'(a_out),   m_stair(0));
        chk("B stair", 32'(b_stair), m_stair(0));
        chk("B out",   32'(b_out),   m_rev(0, m_stair(0)));
        chk("C stair", 32'(c_stair), m_stair(1));
        chk("C out",   32'(c_out),   m_rev(1, m_stair(1)));
        chk("D stair", 32'(d_stair), m_stair(2));
        chk("D out",   32'(d_out),   m_stair(2));
        chk("R stair", 32'(r_stair), m_stair(3));
        chk("R out",   32'(r_out),   m_rev(3, m_stair(3)));
        chk("E stair", 32'(e_stair), m_stair(4));
        chk("E out",   32'(e_out),   m_stair(4));
    endtask

    task automatic clear_hist();
        for (int id = 0; id < 5; id++)
            for (int i = 0; i < 8; i++) hist[id][i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int id = 0; id < 5; id++) begin
                for (int i = 7; i > 0; i--) hist[id][i] = hist[id][i-1];
                hist[id][0] = cur[id];
            end
        end
        #1;
    endtask

    task automatic randomize_streams();
        cur[0] = $urandom & 32'h3F;
        cur[1] = $urandom & 32'h3;
        cur[3] = $urandom & 32'hFFF;
        cur[4] = $urandom & 32'h7;
    endtask

    initial begin
        for (int id = 0; id < 5; id++) cur[id] = '0;
        clear_hist();
        rst = 1'b1;
        #2;
        check_all();

        // Inputs change while held in reset: only undelayed digits may move.
        cur[0] = 32'h3F;
        cur[1] = 32'h3;
        cur[4] = 32'h5;
        #1;
        check_all();
        chk("rst A digit0 follows", 32'(a_stair), 32'h03);
        chk("rst E passthru",       32'(e_out),   32'h5);
        chk("rst C predelay zero",  32'(c_stair), 32'h0);

        // Release between edges, then one-shot pulse on A/B and held 11 on C.
        @(posedge clk);
        #1;
        rst    = 1'b0;
        cur[0] = 32'b11_10_01;
        cur[1] = 32'b11;
        #3;
        for (int c = 0; c < 5; c++) begin
            check_all();
            chk("pulse A stair", 32'(a_stair), 32'(exp_a[c]));
            chk("pulse B out",   32'(b_out),   32'(exp_b[c]));
            chk("hold C stair",  32'(c_stair), 32'(exp_c[c]));
            tick();
            if (c == 0) cur[0] = '0;
            #3;
        end

        // Counter stream on D, random traffic everywhere else.
        for (int c = 0; c < 50; c++) begin
            cur[2] = 32'(cnt) & 32'hFFF;
            randomize_streams();
            #1;
            check_all();
            chk("D digit2", 32'(d_stair[11:8]), m_stair(2) >> 8);
            tick();
            cnt++;
            #3;
        end

        // Fill A/B with all-ones, then reset between clock edges.
        cur[0] = 32'h3F;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_all();
            tick();
            #3;
        end
        chk("full A stair", 32'(a_stair), 32'h3F);
        rst = 1'b1;
        clear_hist();
        #1;
        check_all();
        chk("midrst A cleared", 32'(a_stair), 32'h03);
        cur[0] = 32'b00_00_10;
        #1;
        chk("midrst digit0 follows", 32'(a_stair), 32'h02);
        check_all();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            randomize_streams();
            cur[2] = $urandom & 32'hFFF;
            #2;
            check_all();
            tick();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/pipeline_vector.md
Name: pipeline_vector

Overview:
- Staircase (skewed) select-field delay line for pipelined N-ary mux/demux trees.
- A select word is split into SIZE digits of WIDTH bits. Digit k leaves the block k cycles after digit 0, so each tree level sees its select digit aligned with its data.
- An optional uniform pre-delay, built from the synchronizer sub-module, pads the total latency.
- An optional digit-order reversal maps the MSB digit to the tree root.

Parameters:
- WIDTH, 1, bits per select digit; must be >=1.
- SIZE, 2, number of digits / tree levels; must be >=1.
- PRE_DELAY, 0, extra whole-word register stages ahead of the staircase; must be >=0.
- REVERSE, 1, when 1 sel_out digit order is reversed (digit k takes staircase digit SIZE-1-k); when 0, no reversal.
- PRINT, 0, when nonzero, display the derived register count at elaboration.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sel_in  input  SIZE*WIDTH  select word; digit k is bits [k*WIDTH +: WIDTH].
- sel_stair  output  SIZE*WIDTH  skewed word, natural digit order.
- sel_out  output  SIZE*WIDTH  skewed word after optional digit reversal.

Behaviour:
- Notation: s(t) is sel_in sampled in cycle t; D(x,k) is digit k of x.
- Pre-delay stage: p(t) = s(t-PRE_DELAY).
  - PRE_DELAY=0: p is a purely combinational pass-through of sel_in.
- Staircase:
  - D(sel_stair(t),k) = D(p(t-k),k).
  - Digit 0 is combinational from p.
  - Digit k passes through exactly k registers.
- Total latency of digit k = PRE_DELAY + k cycles.
- Register count = WIDTH*(SIZE*PRE_DELAY + SIZE*(SIZE-1)/2).
  - Digits are never registered beyond their required depth.
- sel_out:
  - REVERSE=1: D(sel_out,k) = D(sel_stair,SIZE-1-k).
  - REVERSE=0: sel_out = sel_stair.
  - Purely combinational; no added latency.
- Reset:
  - rst=1 clears every register to 0 immediately, independent of clk.
  - While rst=1 with PRE_DELAY=0: digit 0 still follows sel_in; all other digits read 0.
  - While rst=1 with PRE_DELAY>0: all outputs read 0.
  - After deassertion, delayed digits read 0 until their pipelines fill.
- Mid-operation reset:
  - In-flight digits are discarded, with no partial recovery.
  - The first post-reset sel_in propagates with normal latency.
- No enable or stall: every register shifts on every rising clk edge.
- SIZE=1: no staircase registers; sel_stair = p.
- WIDTH<1, SIZE<1 or PRE_DELAY<0 is an elaboration-time fatal error.

Decomposition:
- Shared package: digit-field helper (offset k*WIDTH) and a triangular register-count function.
  - Both are reused by the mux/demux tree wrappers.
- Sub-module synchronizer:
  - Parameters WIDTH and DEPTH.
  - DEPTH-stage plain register chain with the same clk/rst; DEPTH=0 is a wire.
  - Instantiated once, WIDTH=SIZE*WIDTH, DEPTH=PRE_DELAY.
- The staircase is a generate loop over digits. Each digit uses either a synchronizer with DEPTH=k or inline shift registers.

Test Plan:
- WIDTH=2, SIZE=3, PRE_DELAY=0, REVERSE=0:
  - Stimulus: sel_in=6'b11_10_01 for one cycle, then 0.
  - sel_stair digit0=01 that cycle, digit1=10 one cycle later, digit2=11 two cycles later; all other digit slots read 0.
- Same configuration with REVERSE=1, same stimulus:
  - sel_out digit2=01 at cycle 0, digit1=10 at cycle 1, digit0=11 at cycle 2.
- PRE_DELAY=2, WIDTH=1, SIZE=2, sel_in=2'b11 held:
  - sel_stair=00 for 2 cycles after reset release, then 01, then 11 steady.
- Async reset mid-flight (WIDTH=2, SIZE=3, PRE_DELAY=0):
  - Load 6'b11_11_11, then assert rst between clock edges.
  - All registered digits drop to 0 without waiting for clk; digit0 keeps following sel_in.
- Continuous stream sel_in = cycle counter (WIDTH=4, SIZE=3):
  - Each cycle, D(sel_stair,k) equals D(counter-k,k), checked for 50 cycles.
- SIZE=1, PRE_DELAY=0:
  - sel_out equals sel_in combinationally, including while rst=1.
